mdu_controller: RTL and testbench
=================================

MDU_CONTROLLER -- requirements
Module: mdu_controller

Interface
REQ-001 Clk  in  1  system clock; all state updates on posedge Clk.
REQ-002 Rst  in  1  synchronous, active-high reset; sampled on posedge Clk only.
REQ-003 Start  in  1  request a multiply/divide; sampled only in IDLE.
REQ-004 Op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with Start.
REQ-005 OperandA  in  32  multiplicand / dividend; latched with Start.
REQ-006 OperandB  in  32  multiplier / divisor; latched with Start.
REQ-007 HiLoRead  in  1  an MFHI/MFLO is in ID and needs the HI/LO result.
REQ-008 Busy  out  1  high when the FSM is not in IDLE.
REQ-009 Stall  out  1  freeze request to the PC and IF/ID stages.
REQ-010 Done  out  1  one-cycle pulse when an operation completes.
REQ-011 HiLoWrite  out  1  HI/LO updated this cycle; equals Done & ~DivByZero.
REQ-012 DivByZero  out  1  one-cycle pulse with Done when the divisor is 0.
REQ-013 HiOut  out  32  registered HI value; held between operations.
REQ-014 LoOut  out  32  registered LO value; held between operations.

Function
REQ-015 The FSM SHALL have five states: IDLE, MUL, DIV, FIX, DONE.
REQ-016 Transitions from IDLE on a posedge with Start=1:
- Op[1]=0: go to MUL, counter=3.
- Op[1]=1 and OperandB!=0: go to DIV, counter=31.
- Op[1]=1 and OperandB=0: go to DONE, DivByZero flag set.
- In every case, operands and Op are latched on that edge.
REQ-017 MUL: counter decrements each cycle; at counter=0 go to DONE. MUL lasts exactly 4 cycles.
REQ-018 DIV: one restoring-division step per cycle on operand magnitudes. Signed ops take absolute values; unsigned ops use raw values. At counter=0 go to FIX. DIV lasts exactly 32 cycles.
REQ-019 FIX: apply signs, then go to DONE.
- Quotient sign = signA XOR signB.
- Remainder sign = signA.
- Unsigned ops pass values through unchanged.
REQ-020 DONE lasts 1 cycle, then goes to IDLE. Done=1 throughout DONE. If HiLoWrite=1, HiOut/LoOut already show the new values in that cycle.
REQ-021 Multiply results: {HiOut,LoOut} = 64-bit product; signed for MULT, unsigned for MULTU.
REQ-022 Divide results: LoOut = quotient, HiOut = remainder.
- 0x80000000 / 0xFFFFFFFF (DIV) gives Lo=0x80000000, Hi=0 (two's-complement wrap).
REQ-023 Divide by zero: HiOut/LoOut unchanged, HiLoWrite=0, DivByZero=1 during DONE.
REQ-024 Latency, counting cycles after the Start-sampling edge:
- MULT/MULTU: Done in cycle 5.
- DIV/DIVU: Done in cycle 34.
- Divide by zero: Done in cycle 1.
REQ-025 Stall = (HiLoRead & state in {MUL,DIV,FIX}) | (Start & state!=IDLE). Stall is combinational from state and inputs.
REQ-026 Start while not IDLE SHALL be ignored. The stalled pipeline re-presents it, and it is accepted on the first IDLE edge.
REQ-027 HiLoRead in DONE or IDLE SHALL NOT stall.
REQ-028 Operand inputs SHALL NOT affect an operation after its Start edge.

Reset
REQ-029 On Rst=1 at a posedge, all of the following SHALL hold, regardless of state:
- State=IDLE and counter=0.
- HiOut=0 and LoOut=0.
- Busy, Done, HiLoWrite and DivByZero = 0.
REQ-030 Rst SHALL take priority over Start.
REQ-031 Reset mid-operation SHALL abandon the operation with no Done pulse.
REQ-032 Stall SHALL be 0 in the cycle after reset unless Start or HiLoRead is asserted with Busy=1, which cannot occur because Busy=0.

Verification
REQ-033 MULTU 0xFFFFFFFF x 0x00000002 -> Done in cycle 5, Hi=0x00000001, Lo=0xFFFFFFFE, HiLoWrite=1.
REQ-034 MULT 0xFFFFFFFD (-3) x 0x00000005 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFF1, Busy=1 in cycles 1-5.
REQ-035 DIV 0xFFFFFFF9 (-7) / 0x00000002 -> Done in cycle 34, Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
REQ-036 Start DIVU 0x0000000A / 0 with Hi=0x1234, Lo=0x5678 set beforehand -> cycle 1: Done=1, DivByZero=1, HiLoWrite=0, Hi/Lo unchanged.
REQ-037 HiLoRead held through a DIVU -> Stall=1 in cycles 1-33, 0 in cycle 34. A second Start in cycle 10 -> Stall=1, and that Start is accepted at the first IDLE edge.
REQ-038 Rst at cycle 10 of a DIV -> next cycle Busy=0, Hi=Lo=0, and no Done pulse in cycles 11-40.

Source files
------------

// File: rtl/mdu_controller.sv
// rtl/mdu_controller.sv - multi-cycle multiply/divide unit with HI/LO registers and pipeline stall control
module mdu_controller (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Start,
   input  logic [1:0]  Op,
   input  logic [31:0] OperandA,
   input  logic [31:0] OperandB,
   input  logic        HiLoRead,
   output logic        Busy,
   output logic        Stall,
   output logic        Done,
   output logic        HiLoWrite,
   output logic        DivByZero,
   output logic [31:0] HiOut,
   output logic [31:0] LoOut
);

   typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

   state_t      state;
   state_t      nextState;
   logic [4:0]  counter;
   logic        mulSigned;
   logic        divZero;
   logic        negQuo;
   logic        negRem;
   logic [31:0] mulA;
   logic [31:0] mulB;
   logic [31:0] quo;
   logic [31:0] rem;
   logic [31:0] divisor;

   // Op[0]=0 selects the signed flavour of both MULT and DIV
   logic        startSigned;
   logic [31:0] absA;
   logic [31:0] absB;
   assign startSigned = ~Op[0];
   assign absA = (startSigned && OperandA[31]) ? (32'd0 - OperandA) : OperandA;
   assign absB = (startSigned && OperandB[31]) ? (32'd0 - OperandB) : OperandB;

   // Sign/zero-extend to 64 bits so one unsigned multiplier yields both signed and unsigned products
   logic [63:0] mulAExt;
   logic [63:0] mulBExt;
   logic [63:0] product;
   assign mulAExt = {{32{mulSigned & mulA[31]}}, mulA};
   assign mulBExt = {{32{mulSigned & mulB[31]}}, mulB};
   assign product = mulAExt * mulBExt;

   // Restoring division trial subtract: shifted partial remainder minus divisor magnitude
   logic [32:0] trial;
   assign trial = {rem, quo[31]} - {1'b0, divisor};

   assign Busy      = (state != IDLE);
   assign Done      = (state == DONE);
   assign DivByZero = Done & divZero;
   assign HiLoWrite = Done & ~divZero;
   assign Stall     = (HiLoRead && (state == MUL || state == DIV || state == FIX))
                    | (Start && state != IDLE);

   // State register
   always_ff @(posedge Clk) begin
      if (Rst) state <= IDLE;
      else     state <= nextState;
   end

   // Next-state logic
   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (Start) begin
               if (!Op[1])              nextState = MUL;
               else if (OperandB != 0)  nextState = DIV;
               else                     nextState = DONE;
            end
         end
         MUL:     if (counter == 5'd0) nextState = DONE;
         DIV:     if (counter == 5'd0) nextState = FIX;
         FIX:     nextState = DONE;
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Operand latching, iteration counter, division steps and HI/LO writeback
   always_ff @(posedge Clk) begin
      if (Rst) begin
         counter   <= 5'd0;
         mulSigned <= 1'b0;
         divZero   <= 1'b0;
         negQuo    <= 1'b0;
         negRem    <= 1'b0;
         mulA      <= 32'd0;
         mulB      <= 32'd0;
         quo       <= 32'd0;
         rem       <= 32'd0;
         divisor   <= 32'd0;
         HiOut     <= 32'd0;
         LoOut     <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (Start) begin
                  counter   <= Op[1] ? 5'd31 : 5'd3;
                  mulSigned <= startSigned;
                  divZero   <= Op[1] && (OperandB == 32'd0);
                  negQuo    <= startSigned & (OperandA[31] ^ OperandB[31]);
                  negRem    <= startSigned & OperandA[31];
                  mulA      <= OperandA;
                  mulB      <= OperandB;
                  quo       <= absA;
                  rem       <= 32'd0;
                  divisor   <= absB;
               end
            end
            MUL: begin
               if (counter == 5'd0) begin
                  HiOut <= product[63:32];
                  LoOut <= product[31:0];
               end else begin
                  counter <= counter - 5'd1;
               end
            end
            DIV: begin
               if (counter != 5'd0) counter <= counter - 5'd1;
               if (!trial[32]) begin
                  rem <= trial[31:0];
                  quo <= {quo[30:0], 1'b1};
               end else begin
                  rem <= {rem[30:0], quo[31]};
                  quo <= {quo[30:0], 1'b0};
               end
            end
            FIX: begin
               HiOut <= negRem ? (32'd0 - rem) : rem;
               LoOut <= negQuo ? (32'd0 - quo) : quo;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_controller.sv
// tb/tb_mdu_controller.sv - scoreboard testbench for mdu_controller
module tb_mdu_controller;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        Start;
   logic [1:0]  Op;
   logic [31:0] OperandA;
   logic [31:0] OperandB;
   logic        HiLoRead;
   logic        Busy;
   logic        Stall;
   logic        Done;
   logic        HiLoWrite;
   logic        DivByZero;
   logic [31:0] HiOut;
   logic [31:0] LoOut;

   mdu_controller dut (
      .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op),
      .OperandA(OperandA), .OperandB(OperandB), .HiLoRead(HiLoRead),
      .Busy(Busy), .Stall(Stall), .Done(Done), .HiLoWrite(HiLoWrite),
      .DivByZero(DivByZero), .HiOut(HiOut), .LoOut(LoOut)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
   } exp_t;

   exp_t sb[$];
   exp_t mexp;
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [31:0] hi, input logic [31:0] lo, input logic dbz);
      exp_t e;
      e.hi  = hi;
      e.lo  = lo;
      e.dbz = dbz;
      sb.push_back(e);
   endtask

   // Monitor: every Done cycle is matched against the oldest expected result
   always @(posedge Clk) begin
      #2;
      if (Done === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 64'(Done), 64'd0);
         end else begin
            mexp = sb.pop_front();
            check("hi_out", 64'(HiOut), 64'(mexp.hi));
            check("lo_out", 64'(LoOut), 64'(mexp.lo));
            check("div_by_zero", 64'(DivByZero), 64'(mexp.dbz));
            check("hilo_write", 64'(HiLoWrite), 64'(!mexp.dbz));
         end
      end
   end

   task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eHi, input logic [31:0] eLo, input logic eDbz,
                        input int eLat, input bit chkBusy);
      int lat;
      push(eHi, eLo, eDbz);
      @(negedge Clk);
      Start = 1'b1; Op = op; OperandA = a; OperandB = b;
      @(posedge Clk);
      #1;
      Start = 1'b0; OperandA = $urandom; OperandB = $urandom; Op = 2'($urandom_range(0, 3));
      #1;
      lat = 0;
      for (int n = 1; n <= 60; n++) begin
         if (chkBusy) check("busy_during_op", 64'(Busy), 64'd1);
         if (Done === 1'b1) begin
            lat = n;
            break;
         end
         @(posedge Clk);
         #2;
      end
      check("latency", 64'(lat), 64'(eLat));
      @(posedge Clk);
      #2;
      check("idle_after_op", 64'(Busy), 64'd0);
   endtask

   initial begin
      int badStall;
      int doneAt;
      int doneCnt;

      Rst = 1'b1; Start = 1'b0; Op = 2'b00; OperandA = 32'd0; OperandB = 32'd0; HiLoRead = 1'b0;
      repeat (2) @(posedge Clk);
      #1 Rst = 1'b0;
      #1;
      check("rst_busy", 64'(Busy), 64'd0);
      check("rst_done", 64'(Done), 64'd0);
      check("rst_hlw", 64'(HiLoWrite), 64'd0);
      check("rst_dbz", 64'(DivByZero), 64'd0);
      check("rst_stall", 64'(Stall), 64'd0);
      check("rst_hi", 64'(HiOut), 64'd0);
      check("rst_lo", 64'(LoOut), 64'd0);

      // op, a, b, expected hi, expected lo, dbz, latency, busy check
      runOp(2'b01, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 1'b0, 5, 1'b0);
      runOp(2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 5, 1'b1);
      runOp(2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34, 1'b0);
      runOp(2'b11, 32'h56781234, 32'h00010000, 32'h00001234, 32'h00005678, 1'b0, 34, 1'b0);
      runOp(2'b11, 32'h0000000A, 32'h00000000, 32'h00001234, 32'h00005678, 1'b1, 1, 1'b1);
      runOp(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34, 1'b0);
      runOp(2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34, 1'b0);
      runOp(2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 5, 1'b0);
      runOp(2'b10, 32'hFFFFFFFF, 32'h00000000, 32'h40000000, 32'h00000000, 1'b1, 1, 1'b0);
      runOp(2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0, 34, 1'b0);
      runOp(2'b01, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000, 1'b0, 5, 1'b0);

      // HiLoRead held through a DIVU: stall in MUL/DIV/FIX cycles only
      push(32'd2, 32'd14, 1'b0);
      @(negedge Clk);
      Start = 1'b1; Op = 2'b11; OperandA = 32'd100; OperandB = 32'd7; HiLoRead = 1'b1;
      @(posedge Clk);
      #1 Start = 1'b0;
      #1;
      badStall = 0;
      for (int n = 1; n <= 33; n++) begin
         if (Stall !== 1'b1) badStall++;
         @(posedge Clk);
         #2;
      end
      check("stall_hlr_c1_33", 64'(badStall), 64'd0);
      check("stall_hlr_done", 64'(Stall), 64'd0);
      check("done_c34", 64'(Done), 64'd1);
      @(posedge Clk);
      #2;
      check("stall_hlr_idle", 64'(Stall), 64'd0);
      HiLoRead = 1'b0;

      // Second Start presented in cycle 10 is held and accepted on the first IDLE edge
      push(32'd0, 32'd10, 1'b0);
      push(32'd0, 32'd12, 1'b0);
      @(negedge Clk);
      Start = 1'b1; Op = 2'b11; OperandA = 32'd100; OperandB = 32'd10;
      @(posedge Clk);
      #1 Start = 1'b0;
      #1;
      for (int n = 1; n <= 9; n++) begin
         @(posedge Clk);
         #2;
      end
      Start = 1'b1; Op = 2'b01; OperandA = 32'd3; OperandB = 32'd4;
      #1;
      check("stall_start_busy", 64'(Stall), 64'd1);
      #1;
      doneAt = 0;
      for (int n = 10; n <= 60; n++) begin
         if (Done === 1'b1) begin
            doneAt = n;
            break;
         end
         @(posedge Clk);
         #2;
      end
      check("first_done_cycle", 64'(doneAt), 64'd34);
      check("stall_start_done", 64'(Stall), 64'd1);
      @(posedge Clk);
      #2;
      check("idle_before_accept", 64'(Busy), 64'd0);
      check("stall_start_idle", 64'(Stall), 64'd0);
      @(posedge Clk);
      #1 Start = 1'b0;
      #1;
      check("second_accepted", 64'(Busy), 64'd1);
      doneAt = 0;
      for (int n = 36; n <= 60; n++) begin
         if (Done === 1'b1) begin
            doneAt = n;
            break;
         end
         @(posedge Clk);
         #2;
      end
      check("second_done_cycle", 64'(doneAt), 64'd40);
      @(posedge Clk);
      #2;

      // Reset in cycle 10 of a DIV abandons it without a Done pulse
      @(negedge Clk);
      Start = 1'b1; Op = 2'b10; OperandA = 32'h00001000; OperandB = 32'd3;
      @(posedge Clk);
      #1 Start = 1'b0;
      #1;
      for (int n = 1; n <= 9; n++) begin
         @(posedge Clk);
         #2;
      end
      Rst = 1'b1;
      @(posedge Clk);
      #1 Rst = 1'b0;
      #1;
      check("midrst_busy", 64'(Busy), 64'd0);
      check("midrst_hi", 64'(HiOut), 64'd0);
      check("midrst_lo", 64'(LoOut), 64'd0);
      check("midrst_stall", 64'(Stall), 64'd0);
      doneCnt = 0;
      for (int n = 11; n <= 40; n++) begin
         if (Done !== 1'b0) doneCnt++;
         @(posedge Clk);
         #2;
      end
      check("midrst_no_done", 64'(doneCnt), 64'd0);

      // Reset wins over a simultaneous Start
      @(negedge Clk);
      Rst = 1'b1; Start = 1'b1; Op = 2'b00; OperandA = 32'd2; OperandB = 32'd2;
      @(posedge Clk);
      #1 Rst = 1'b0; Start = 1'b0;
      #1;
      check("rst_over_start", 64'(Busy), 64'd0);
      repeat (8) @(posedge Clk);
      #2;

      check("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
